// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Types and instruction-field constants shared between the
//                instruction issuer and the control unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Issuer sequencing states. The width is fixed so the encoding stays
    // stable across tools.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        RUN    = 3'd2,
        FINISH = 3'd3,
        ERR    = 3'd4
    } issue_state_t;

    // Instruction field positions: [15:13] dst, [12:10] src, [4:2] alu sel.
    localparam int DST_MSB = 15;
    localparam int SRC_MSB = 12;
    localparam int ALU_MSB = 4;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/inst_issue_if.sv
`default_nettype none
// ============================================================================
//  Module      : inst_issue_if
//  Description : run/d_inst/done handshake between the instruction issuer
//                (master) and the control unit (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface inst_issue_if #(
    parameter int IW = 16
) ();

    logic          run;
    logic [IW-1:0] d_inst;
    logic          done;

    modport master (output run, output d_inst, input done);
    modport slave  (input run, input d_inst, output done);

endinterface : inst_issue_if
`default_nettype wire

// File: rtl/inst_mem.sv
`default_nettype none
// ============================================================================
//  Module      : inst_mem
//  Description : DEPTH x IW program store, one write port and one
//                synchronous read port. Contents are not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_mem #(
    parameter int DEPTH = 16,
    parameter int IW    = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  wire logic          clk,
    input  wire logic          we,
    input  wire logic [AW-1:0] waddr,
    input  wire logic [IW-1:0] wdata,
    input  wire logic          re,
    input  wire logic [AW-1:0] raddr,
    output logic      [IW-1:0] rdata
);

    logic [IW-1:0] r_mem [DEPTH];
    logic [IW-1:0] r_rdata;

    // Write port and registered read port; the read register holds between reads.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
        if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule : inst_mem
`default_nettype wire

// File: rtl/inst_issue.sv
`default_nettype none
// ============================================================================
//  Module      : inst_issue
//  Description : Instruction sequencer. Fetches one instruction at a time
//                from a loadable program, holds run until the control unit
//                returns done, and flags a control unit that never completes.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_issue
    import cpu_pkg::*;
#(
    parameter  int DEPTH   = 16,
    parameter  int IW      = 16,
    parameter  int TIMEOUT = 15,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = $clog2(TIMEOUT + 1)
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic          load_we,
    input  wire logic [AW-1:0] load_addr,
    input  wire logic [IW-1:0] load_data,
    input  wire logic [AW:0]   prog_len,
    input  wire logic          start,
    inst_issue_if.master       cu,
    output logic               busy,
    output logic      [AW-1:0] pc,
    output logic               finished,
    output logic               err
);

    localparam logic [AW:0]   c_depth   = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] c_timeout = CW'(TIMEOUT);

    issue_state_t  r_state, w_state_n;
    logic [AW-1:0] r_pc, w_pc_n;
    logic [AW:0]   r_len, w_len_n;
    logic [CW-1:0] r_wd, w_wd_n;
    logic          r_run, w_run_n;
    logic          r_err, w_err_n;
    logic          r_fin, w_fin_n;
    logic          r_inst_vld;
    logic          w_mem_we, w_mem_re;
    logic [IW-1:0] w_rdata;
    logic          w_last;

    // The memory's read register doubles as the d_inst output register, so
    // the fetched word reaches the control unit on the same edge run rises.
    inst_mem #(.DEPTH(DEPTH), .IW(IW), .AW(AW)) u_mem (
        .clk   (clk),
        .we    (w_mem_we),
        .waddr (load_addr),
        .wdata (load_data),
        .re    (w_mem_re),
        .raddr (r_pc),
        .rdata (w_rdata)
    );

    assign w_last = ({1'b0, r_pc} == (r_len - (AW + 1)'(1)));

    // Next-state and next-register values; everything holds unless a state acts.
    always_comb begin
        w_state_n = r_state;
        w_pc_n    = r_pc;
        w_len_n   = r_len;
        w_wd_n    = r_wd;
        w_run_n   = r_run;
        w_err_n   = r_err;
        w_fin_n   = 1'b0;
        w_mem_we  = 1'b0;
        w_mem_re  = 1'b0;
        case (r_state)
            IDLE: begin
                w_mem_we = load_we;
                if (start) begin
                    w_err_n = 1'b0;
                    if (prog_len == '0) begin
                        w_fin_n = 1'b1;
                    end else begin
                        w_len_n   = (prog_len > c_depth) ? c_depth : prog_len;
                        w_pc_n    = '0;
                        w_state_n = FETCH;
                    end
                end
            end
            FETCH: begin
                w_mem_re  = 1'b1;
                w_run_n   = 1'b1;
                w_wd_n    = '0;
                w_state_n = RUN;
            end
            RUN: begin
                if (cu.done) begin
                    w_run_n = 1'b0;
                    if (w_last) begin
                        w_fin_n   = 1'b1;
                        w_state_n = FINISH;
                    end else begin
                        w_pc_n    = r_pc + AW'(1);
                        w_state_n = FETCH;
                    end
                end else if (r_wd == c_timeout) begin
                    w_run_n   = 1'b0;
                    w_err_n   = 1'b1;
                    w_state_n = ERR;
                end else begin
                    w_wd_n = r_wd + CW'(1);
                end
            end
            FINISH: begin
                w_run_n   = 1'b0;
                w_state_n = IDLE;
            end
            ERR: begin
                w_state_n = IDLE;
            end
            default: begin
                w_run_n   = 1'b0;
                w_state_n = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_pc       <= '0;
            r_len      <= '0;
            r_wd       <= '0;
            r_run      <= 1'b0;
            r_err      <= 1'b0;
            r_fin      <= 1'b0;
            r_inst_vld <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_pc    <= w_pc_n;
            r_len   <= w_len_n;
            r_wd    <= w_wd_n;
            r_run   <= w_run_n;
            r_err   <= w_err_n;
            r_fin   <= w_fin_n;
            if (w_mem_re) begin
                r_inst_vld <= 1'b1;
            end
        end
    end

    // d_inst reads as zero until the first fetch after reset.
    assign cu.d_inst = r_inst_vld ? w_rdata : '0;
    assign cu.run    = r_run;
    assign busy      = (r_state != IDLE);
    assign pc        = r_pc;
    assign finished  = r_fin;
    assign err       = r_err;

endmodule : inst_issue
`default_nettype wire

// File: tb/tb_inst_issue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_issue
//  Description : Directed self-checking bench for inst_issue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_issue;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_we;
    logic [3:0]  load_addr;
    logic [15:0] load_data;
    logic [4:0]  prog_len;
    logic        start;
    logic        busy;
    logic [3:0]  pc;
    logic        finished;
    logic        err;

    int n_checks = 0;
    int n_fails  = 0;
    int run_cnt;

    inst_issue_if #(.IW(16)) cu_if ();

    inst_issue #(.DEPTH(16), .IW(16), .TIMEOUT(15)) dut (
        .clk       (clk),
        .reset     (reset),
        .load_we   (load_we),
        .load_addr (load_addr),
        .load_data (load_data),
        .prog_len  (prog_len),
        .start     (start),
        .cu        (cu_if.master),
        .busy      (busy),
        .pc        (pc),
        .finished  (finished),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [3:0] a, input logic [15:0] d);
        load_we   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_we   = 1'b0;
    endtask

    // Entered just after run rises: check issue, wait, return done, check drop.
    task automatic serve(input logic [15:0] exp_inst, input logic [3:0] exp_pc,
                         input int nwait, input bit last);
        chk("run_hi", 32'(cu_if.run), 32'd1);
        chk("d_inst", 32'(cu_if.d_inst), 32'(exp_inst));
        chk("pc_run", 32'(pc), 32'(exp_pc));
        repeat (nwait) tick();
        chk("run_held", 32'(cu_if.run), 32'd1);
        cu_if.done = 1'b1;
        tick();
        cu_if.done = 1'b0;
        chk("run_drop", 32'(cu_if.run), 32'd0);
        chk("d_hold", 32'(cu_if.d_inst), 32'(exp_inst));
        if (last) begin
            chk("fin_pulse", 32'(finished), 32'd1);
            chk("pc_last", 32'(pc), 32'(exp_pc));
            tick();
            chk("fin_clear", 32'(finished), 32'd0);
            chk("busy_end", 32'(busy), 32'd0);
        end else begin
            chk("fin_mid", 32'(finished), 32'd0);
            chk("pc_adv", 32'(pc), 32'(exp_pc + 4'd1));
            chk("busy_gap", 32'(busy), 32'd1);
            tick();
        end
    endtask

    task automatic run_prog3();
        prog_len = 5'd3;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        chk("busy_fetch", 32'(busy), 32'd1);
        chk("run_fetch", 32'(cu_if.run), 32'd0);
        tick();
        serve(16'h2400, 4'd0, 2, 1'b0);
        serve(16'h4808, 4'd1, 2, 1'b0);
        serve(16'h6C0C, 4'd2, 2, 1'b1);
        chk("pc_idle", 32'(pc), 32'd2);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no end expected end");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset       = 1'b1;
        load_we     = 1'b0;
        load_addr   = '0;
        load_data   = '0;
        prog_len    = '0;
        start       = 1'b0;
        cu_if.done  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_run", 32'(cu_if.run), 32'd0);
        chk("rst_dinst", 32'(cu_if.d_inst), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_fin", 32'(finished), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // Three-instruction program with a 3-cycle responder.
        load(4'd0, 16'h2400);
        load(4'd1, 16'h4808);
        load(4'd2, 16'h6C0C);
        run_prog3();

        // Empty program.
        prog_len = 5'd0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        chk("empty_fin", 32'(finished), 32'd1);
        chk("empty_busy", 32'(busy), 32'd0);
        chk("empty_run", 32'(cu_if.run), 32'd0);
        tick();
        chk("empty_fin_off", 32'(finished), 32'd0);
        chk("empty_busy2", 32'(busy), 32'd0);

        // Watchdog: done never arrives.
        prog_len = 5'd1;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        tick();
        run_cnt = 0;
        for (int i = 0; i < 40 && cu_if.run; i++) begin
            run_cnt++;
            tick();
        end
        chk("wd_run_cycles", 32'(run_cnt), 32'd16);
        chk("wd_err", 32'(err), 32'd1);
        chk("wd_pc", 32'(pc), 32'd0);
        tick();
        chk("wd_err_sticky", 32'(err), 32'd1);
        chk("wd_idle", 32'(busy), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("wd_err_clear", 32'(err), 32'd0);
        tick();
        cu_if.done = 1'b1;
        tick();
        cu_if.done = 1'b0;
        chk("wd_recover_fin", 32'(finished), 32'd1);
        tick();

        // done exactly at the last watchdog count.
        prog_len = 5'd2;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        tick();
        repeat (15) tick();
        chk("edge_run_hi", 32'(cu_if.run), 32'd1);
        cu_if.done = 1'b1;
        tick();
        cu_if.done = 1'b0;
        chk("edge_no_err", 32'(err), 32'd0);
        chk("edge_run_lo", 32'(cu_if.run), 32'd0);
        chk("edge_pc", 32'(pc), 32'd1);
        tick();
        chk("edge_next_run", 32'(cu_if.run), 32'd1);
        chk("edge_next_inst", 32'(cu_if.d_inst), 32'h4808);
        cu_if.done = 1'b1;
        tick();
        cu_if.done = 1'b0;
        chk("edge_fin", 32'(finished), 32'd1);
        chk("edge_err_end", 32'(err), 32'd0);
        tick();

        // Reset in the second RUN cycle, then restart without reloading.
        prog_len = 5'd3;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_run", 32'(cu_if.run), 32'd0);
        chk("mid_rst_pc", 32'(pc), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        run_prog3();

        // Same-cycle load and start; loads while busy are ignored.
        load_we   = 1'b1;
        load_addr = 4'd0;
        load_data = 16'hA5A5;
        prog_len  = 5'd1;
        start     = 1'b1;
        tick();
        load_we   = 1'b0;
        start     = 1'b0;
        tick();
        chk("ls_run", 32'(cu_if.run), 32'd1);
        chk("ls_dinst", 32'(cu_if.d_inst), 32'hA5A5);
        load_we    = 1'b1;
        load_data  = 16'hFFFF;
        start      = 1'b1;
        cu_if.done = 1'b1;
        tick();
        cu_if.done = 1'b0;
        chk("ls_fin", 32'(finished), 32'd1);
        tick();
        load_we = 1'b0;
        start   = 1'b0;
        chk("ls_idle", 32'(busy), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("ls_mem_kept", 32'(cu_if.d_inst), 32'hA5A5);
        cu_if.done = 1'b1;
        tick();
        cu_if.done = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_inst_issue
`default_nettype wire
